// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the common data bus.
// One grant per cycle; the granted result is broadcast one cycle later.
module cdb_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_REQ     = 4,
    parameter int RS_ID_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_result,
    input  logic [NUM_REQ*RS_ID_WIDTH-1:0] req_rs_id,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           flush,
    output logic                           CDB_valid,
    output logic [DATA_WIDTH-1:0]          CDB_result,
    output logic [RS_ID_WIDTH-1:0]         CDB_rs_id,
    output logic [15:0]                    grant_count
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]       r_ptr;
    logic                   r_cdb_valid;
    logic [DATA_WIDTH-1:0]  r_cdb_result;
    logic [RS_ID_WIDTH-1:0] r_cdb_rs_id;
    logic [15:0]            r_grant_count;

    logic                   w_arb_en;
    logic                   w_found;
    logic                   w_any;
    logic [PTR_W:0]         w_sum;
    logic [PTR_W-1:0]       w_gidx;
    logic [PTR_W-1:0]       w_ptr_nxt;
    logic [NUM_REQ-1:0]     w_grant;
    logic [DATA_WIDTH-1:0]  w_gresult;
    logic [RS_ID_WIDTH-1:0] w_grs_id;

    // No grant while held in reset or while the branch unit flushes.
    assign w_arb_en = rst & ~flush;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            if (!w_found && req_valid[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[PTR_W-1:0];
            end
        end
    end

    assign w_any = w_found & w_arb_en;

    always_comb begin
        w_grant   = '0;
        w_gresult = '0;
        w_grs_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_any && (w_gidx == PTR_W'(i))) begin
                w_grant[i] = 1'b1;
                w_gresult  = req_result[i*DATA_WIDTH +: DATA_WIDTH];
                w_grs_id   = req_rs_id[i*RS_ID_WIDTH +: RS_ID_WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_gidx == LAST) ? '0 : w_gidx + PTR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_result <= '0;
            r_cdb_rs_id  <= '0;
        end else begin
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb_result <= w_gresult;
                r_cdb_rs_id  <= w_grs_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant_count <= '0;
        end else if (w_any && (r_grant_count != 16'hFFFF)) begin
            r_grant_count <= r_grant_count + 16'd1;
        end
    end

    assign req_ready   = w_grant;
    assign CDB_valid   = r_cdb_valid;
    assign CDB_result  = r_cdb_result;
    assign CDB_rs_id   = r_cdb_rs_id;
    assign grant_count = r_grant_count;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus among the functional-unit reservation stations (BU, ALU, LSU, ...), which produce results on CDB_valid/CDB_result/CDB_rs_id.
- Grants at most one requester per cycle using round-robin priority and drives the registered bus broadcast on the next cycle.
- A flush input, driven by the branch unit on a mispredict, cancels the in-flight broadcast and suppresses new grants.

Parameters:
- DATA_WIDTH, 64, width of a result word.
- NUM_REQ, 4, number of requesting functional units (2..8).
- RS_ID_WIDTH, 3, width of a reservation-station tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i high means requester i holds a finished result.
- req_result  input  NUM_REQ*DATA_WIDTH  result of requester i, in slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_rs_id  input  NUM_REQ*RS_ID_WIDTH  tag of requester i, in slice [i*RS_ID_WIDTH +: RS_ID_WIDTH].
- req_ready  output  NUM_REQ  one-hot or zero; bit i high means requester i is granted this cycle.
- flush  input  1  cancel the broadcast and block grants this cycle.
- CDB_valid  output  1  broadcast valid, registered.
- CDB_result  output  DATA_WIDTH  broadcast result, registered.
- CDB_rs_id  output  RS_ID_WIDTH  broadcast tag, registered.
- grant_count  output  16  total broadcasts since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (rst low, asynchronous): CDB_valid=0, CDB_result=0, CDB_rs_id=0, grant_count=0, round-robin pointer ptr=0.
  - While rst is low, req_ready=0.
  - The first cycle after reset release gives requester 0 highest priority.
- Grant (combinational in cycle T):
  - If flush=0, req_ready selects the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - If no requester is valid, req_ready=0.
  - If flush=1, req_ready=0 regardless of the requests.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - A requester must hold req_valid, req_result and req_rs_id stable until it is granted.
  - A requester must not drop req_valid without a grant; the bench flags a violation with an assertion.
  - The requester deasserts (or presents its next result) in the cycle after the grant.
- Broadcast latency: exactly 1 cycle.
  - A grant in cycle T gives, at edge T+1: CDB_valid=1, CDB_result=req_result[g], CDB_rs_id=req_rs_id[g].
  - If there is no grant in T, CDB_valid=0 at T+1, and CDB_result/CDB_rs_id hold their previous values.
  - Back-to-back grants produce one broadcast per cycle, with no bubbles.
- Pointer: on a grant to g, ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ cycles.
- Flush:
  - flush=1 in cycle T forces CDB_valid=0 at T+1, even if a grant was pending.
  - ptr and grant_count hold.
  - Requesters keep their valid; arbitration resumes from the unchanged ptr in the first cycle with flush=0.
- grant_count: increments by 1 on each grant; it holds at 16'hFFFF once saturated.
- Reset mid-operation: all state clears immediately (asynchronously), and any ungranted request is simply re-arbitrated after release.
- Single requester valid: it is granted every cycle it is valid, whatever ptr is.

Test Plan:
- Reset, then assert req_valid=4'b0001 with result 64'hDEAD, id 3'd5 → req_ready=4'b0001 same cycle; next cycle CDB_valid=1, CDB_result=64'hDEAD, CDB_rs_id=5, grant_count=1.
- All four requesters valid continuously from reset → grants 0,1,2,3,0 on consecutive cycles; CDB_valid stays high for 5 cycles; CDB_rs_id follows each requester's tag.
- ptr=2 (after granting 1), req_valid=4'b0011 → requester 0 granted before 1 in the next cycle, then 1.
- Requester 3 granted in cycle T while flush=1 in cycle T → req_ready=0 in T, CDB_valid=0 at T+1, ptr unchanged; flush low at T+1 → 3 granted, CDB_valid=1 at T+2.
- Drop rst while CDB_valid=1 and grant_count=7 → outputs go to 0 before the next edge; after release requester 0 has priority.
- Force grant_count to 16'hFFFE, perform 3 grants → counter reads 16'hFFFF and stays there.
